// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array sequencer: FSM state encoding,
// element widths and a lane-slicing macro for flat WIDTH*8 row buses.
`ifndef SYSTOLIC_PKG_MACROS
`define SYSTOLIC_PKG_MACROS
// Byte lane k of a flat row vector.
`define SYS_LANE(v, k) v[systolic_pkg::INT8_W*(k) +: systolic_pkg::INT8_W]
`endif

package systolic_pkg;
  localparam int INT8_W = 8;
  localparam int PSUM_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_W = 3'd1,
    ST_SWITCH = 3'd2,
    ST_STREAM = 3'd3,
    ST_DRAIN  = 3'd4,
    ST_DONE   = 3'd5
  } state_e;
endpackage

// File: rtl/skew_buf.sv
// Triangular delay line: lane i is delayed i cycles, data and valid together.
// Lane 0 is a pass-through. Asynchronous clear on rst.
module skew_buf
  import systolic_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [WIDTH-1:0][INT8_W-1:0]  din,
  input  logic                          vin,
  output logic [WIDTH-1:0][INT8_W-1:0]  dout,
  output logic [WIDTH-1:0]              vout
);
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    if (i == 0) begin : g_pass
      assign dout[i] = din[i];
      assign vout[i] = vin;
    end else begin : g_dly
      logic [i-1:0][INT8_W-1:0] d_sr;
      logic [i-1:0]             v_sr;

      // Shift lane i's byte and valid through i register stages.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          d_sr <= '0;
          v_sr <= '0;
        end else begin
          d_sr[0] <= din[i];
          v_sr[0] <= vin;
          for (int k = 1; k < i; k++) begin
            d_sr[k] <= d_sr[k-1];
            v_sr[k] <= v_sr[k-1];
          end
        end
      end

      assign dout[i] = d_sr[i-1];
      assign vout[i] = v_sr[i-1];
    end
  end
endmodule

// File: rtl/systolic_ctrl.sv
// Systolic array sequencer: takes one matmul command, loads weights bottom
// row first, pulses switch, then streams row-skewed input vectors.
// Optional SYSTOLIC_CTRL_PERF_EN adds perf_cycles (busy cycles of last command).
module systolic_ctrl
  import systolic_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 16,
  parameter int UB_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_W-1:0]     cmd_w_addr,
  input  logic [ADDR_W-1:0]     cmd_a_addr,
  input  logic [15:0]           cmd_m,
  input  logic [15:0]           cmd_n,
  output logic                  ub_rd_en,
  output logic [ADDR_W-1:0]     ub_rd_addr,
  input  logic [WIDTH*8-1:0]    ub_rd_data,
  output logic [WIDTH*8-1:0]    sys_weight,
  output logic [WIDTH-1:0]      sys_accept_w,
  output logic [WIDTH*8-1:0]    sys_data,
  output logic [WIDTH-1:0]      sys_start,
  output logic                  sys_switch,
  output logic [15:0]           col_size,
  output logic                  col_size_valid,
  output logic                  busy,
  output logic                  done,
  output logic                  cmd_err
`ifdef SYSTOLIC_CTRL_PERF_EN
  ,
  output logic [31:0]           perf_cycles
`endif
);
  localparam int LOAD_CYC  = WIDTH + UB_LAT;
  localparam int DRAIN_CYC = UB_LAT + 3*WIDTH;

  state_e              state;
  logic [15:0]         cnt;
  logic [15:0]         m_r;
  logic [ADDR_W-1:0]   a_addr_r;
  logic [WIDTH-1:0]    col_mask;
  logic [WIDTH-1:0]    mask_next;
  logic                rd_is_w;
  logic                cmd_bad;
  logic [UB_LAT-1:0]   w_pipe;
  logic [UB_LAT-1:0]   a_pipe;
  logic                w_ret;
  logic                a_ret;

  logic [WIDTH-1:0][INT8_W-1:0] skew_din;
  logic [WIDTH-1:0][INT8_W-1:0] skew_dout;

  assign cmd_bad = (cmd_m == 16'd0) || (cmd_n == 16'd0) || (int'(cmd_n) > WIDTH);

  // Active-column mask derived from the offered column count.
  always_comb begin
    mask_next = '0;
    for (int j = 0; j < WIDTH; j++)
      mask_next[j] = (j < int'(cmd_n));
  end

  // Command sequencer: phase counting, UB address generation, registered controls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_IDLE;
      cnt            <= '0;
      m_r            <= '0;
      a_addr_r       <= '0;
      col_mask       <= '0;
      rd_is_w        <= 1'b0;
      ub_rd_en       <= 1'b0;
      ub_rd_addr     <= '0;
      sys_switch     <= 1'b0;
      col_size       <= '0;
      col_size_valid <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      cmd_err        <= 1'b0;
      cmd_ready      <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            if (cmd_bad) begin
              state   <= ST_DONE;
              done    <= 1'b1;
              cmd_err <= 1'b1;
            end else begin
              state          <= ST_LOAD_W;
              cnt            <= '0;
              m_r            <= cmd_m;
              a_addr_r       <= cmd_a_addr;
              col_mask       <= mask_next;
              col_size       <= cmd_n;
              col_size_valid <= 1'b1;
              rd_is_w        <= 1'b1;
              ub_rd_en       <= 1'b1;
              ub_rd_addr     <= cmd_w_addr + ADDR_W'(WIDTH - 1);
            end
          end
        end
        ST_LOAD_W: begin
          // Reads go out during the first WIDTH cycles; the rest waits for returns.
          col_size_valid <= 1'b0;
          ub_rd_en       <= (cnt < 16'(WIDTH - 1));
          ub_rd_addr     <= ub_rd_addr - ADDR_W'(1);
          cnt            <= cnt + 16'd1;
          if (cnt == 16'(LOAD_CYC - 1)) begin
            state      <= ST_SWITCH;
            sys_switch <= 1'b1;
          end
        end
        ST_SWITCH: begin
          state      <= ST_STREAM;
          sys_switch <= 1'b0;
          rd_is_w    <= 1'b0;
          ub_rd_en   <= 1'b1;
          ub_rd_addr <= a_addr_r;
          cnt        <= '0;
        end
        ST_STREAM: begin
          if (cnt == m_r - 16'd1) begin
            state    <= ST_DRAIN;
            ub_rd_en <= 1'b0;
            cnt      <= '0;
          end else begin
            ub_rd_addr <= ub_rd_addr + ADDR_W'(1);
            cnt        <= cnt + 16'd1;
          end
        end
        ST_DRAIN: begin
          cnt <= cnt + 16'd1;
          if (cnt == 16'(DRAIN_CYC - 1)) begin
            state   <= ST_DONE;
            done    <= 1'b1;
            cmd_err <= 1'b0;
          end
        end
        ST_DONE: begin
          state     <= ST_IDLE;
          done      <= 1'b0;
          cmd_err   <= 1'b0;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Track which UB returns are weight rows and which are input rows.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_pipe <= '0;
      a_pipe <= '0;
    end else begin
      w_pipe <= UB_LAT'({w_pipe, ub_rd_en &  rd_is_w});
      a_pipe <= UB_LAT'({a_pipe, ub_rd_en & ~rd_is_w});
    end
  end

  assign w_ret = w_pipe[UB_LAT-1];
  assign a_ret = a_pipe[UB_LAT-1];

  // Returned weight rows go straight to the array, inactive columns zeroed.
  always_comb begin
    sys_weight = '0;
    for (int j = 0; j < WIDTH; j++)
      if (w_ret && col_mask[j])
        `SYS_LANE(sys_weight, j) = `SYS_LANE(ub_rd_data, j);
  end

  assign sys_accept_w = w_ret ? col_mask : '0;

  // Input rows are zeroed when not valid so idle lanes stay 0 through the skew.
  assign skew_din = a_ret ? ub_rd_data : '0;

  skew_buf #(.WIDTH(WIDTH)) u_skew (
    .clk  (clk),
    .rst  (rst),
    .din  (skew_din),
    .vin  (a_ret),
    .dout (skew_dout),
    .vout (sys_start)
  );

  assign sys_data = skew_dout;

`ifdef SYSTOLIC_CTRL_PERF_EN
  // Busy-cycle counter for the most recent command, saturating.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      perf_cycles <= '0;
    else if (state == ST_IDLE && cmd_valid)
      perf_cycles <= '0;
    else if (busy && perf_cycles != 32'hFFFF_FFFF)
      perf_cycles <= perf_cycles + 32'd1;
  end
`endif
endmodule
